lead_one_norm: RTL and testbench
================================

LEAD_ONE_NORM -- requirements
Module: lead_one_norm

Interface
REQ-001 SHALL have parameter width, default 8: operand word width, 2 or more.
REQ-002 SHALL have parameter speed, type lau_pkg::speed_e, default lau_pkg::FAST: passed unchanged to the internal LeadOneDet prefix structure.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port valid_i, input, 1 bit: input operand valid.
REQ-006 SHALL have port ready_o, output, 1 bit: block accepts the input this cycle.
REQ-007 SHALL have port a_i, input, width bits: operand.
REQ-008 SHALL have port lzc_mode_i, input, 1 bit: 1 counts leading zeros (operand inverted before detection), 0 counts leading ones.
REQ-009 SHALL have port valid_o, output, 1 bit: result valid.
REQ-010 SHALL have port ready_i, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port data_o, output, width bits: operand shifted left by cnt_o, zero-filled.
REQ-012 SHALL have port cnt_o, output, $clog2(width)+1 bits: leading count, range 0..width.
REQ-013 SHALL have port full_o, output, 1 bit: 1 when the detected operand is all ones (cnt_o = width).

Function
REQ-014 SHALL define the detected operand D as a_i when lzc_mode_i=0 and ~a_i when lzc_mode_i=1.
REQ-015 SHALL set cnt_o to the number of consecutive 1s in D from the MSB, obtained from the one-hot first-'0' position.
REQ-016 SHALL set data_o to the original a_i (not D) shifted left by cnt_o, with zeros shifted in.
REQ-017 SHALL, when cnt_o = width, drive data_o = 0 and full_o = 1; otherwise full_o = 0.
REQ-018 SHALL transfer an input when valid_i && ready_o, and an output when valid_o && ready_i.
REQ-019 SHALL drive ready_o = !valid_q || ready_i per pipeline stage (full throughput, one result per cycle, no combinational path from valid_i to valid_o).
REQ-020 SHALL hold valid_o, data_o, cnt_o and full_o stable while valid_o && !ready_i.
REQ-021 SHALL not drop or duplicate an operand when a new input and an output transfer occur in the same cycle.
REQ-022 SHALL produce results in input order; latency is 2 cycles with LAU_NORM_PIPE2_EN, otherwise 1 cycle.
REQ-023 SHALL capture the data registers only on an accepted transfer; the valid registers are the only control state.

Reset
REQ-024 SHALL, on rst_ni low, immediately clear every valid register, so valid_o=0, data_o=0, cnt_o=0, full_o=0.
REQ-025 SHALL discard in-flight operands when reset is asserted mid-operation; the first valid_o after release belongs to an input accepted after release.
REQ-026 SHALL drive ready_o = 1 during and after reset.

Configuration
REQ-027 SHALL, when LAU_NORM_PIPE2_EN is defined, register after detection (stage 1: D, count) and after shifting (stage 2: outputs), giving 2-cycle latency.
REQ-028 SHALL, when LAU_NORM_PIPE2_EN is undefined, perform detection, encoding and shifting in one stage with a single output register, giving 1-cycle latency, and keep the same ports and handshake.

Structure
REQ-029 SHALL place in lau_pkg a constant function for the count width, $clog2(width)+1, and a struct typedef lau_norm_res holding data, cnt and full.
REQ-030 SHALL instantiate LeadOneDet for detection and a new sub-module onehot_enc (one-hot to binary, with an all-zero input mapping to width) for encoding.

Verification
REQ-031 SHALL cover: width=8, mode 0, a_i=8'b11101010 -> cnt_o=3, data_o=8'b01010000, full_o=0.
REQ-032 SHALL cover: mode 1, a_i=8'b00010110 -> cnt_o=3, data_o=8'b10110000.
REQ-033 SHALL cover: mode 0, a_i=8'hFF -> cnt_o=8, data_o=8'h00, full_o=1; mode 0, a_i=8'h00 -> cnt_o=0, data_o=8'h00.
REQ-034 SHALL cover: back-to-back valid_i with ready_i held low for 3 cycles -> outputs frozen, ready_o=0 once the pipe is full, no loss on release, order preserved.
REQ-035 SHALL cover: rst_ni pulsed low with 2 operands in flight -> valid_o=0 at once, none of those operands appear later.
REQ-036 SHALL cover: random streams in both macro settings compared against a reference count -> latency of exactly 2 or 1 cycles respectively.

Source files
------------

// File: rtl/lau_pkg.sv
// Shared types and helpers for the lead-one normaliser.
// Struct fields are sized for the widest supported operand (LAU_MAX_W).
package lau_pkg;

  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

  localparam int unsigned LAU_MAX_W  = 256;
  localparam int unsigned LAU_MAX_CW = 9;

  function automatic int unsigned cnt_width(input int unsigned w);
    return 32'($clog2(w)) + 32'd1;
  endfunction

  typedef struct packed {
    logic [LAU_MAX_W-1:0]  data;
    logic [LAU_MAX_CW-1:0] cnt;
    logic                  full;
  } lau_norm_res;

endpackage

// File: rtl/LeadOneDet.sv
// One-hot position of the first '0' below an MSB-aligned run of ones.
// FAST uses a log-depth prefix AND; SLOW uses a ripple chain.
module LeadOneDet
  import lau_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter speed_e      speed = FAST
) (
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_onehot_c
);

  localparam int unsigned LVLS = $clog2(width);

  // w_sfx[b] = &i_d[width-1:b]
  logic [width-1:0] w_sfx;

  if (speed == FAST) begin : g_fast
    logic [width-1:0] w_pre [LVLS+1];
    assign w_pre[0] = i_d;
    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
      for (genvar b = 0; b < width; b++) begin : g_bit
        if (b + (1 << l) < width) begin : g_and
          assign w_pre[l+1][b] = w_pre[l][b] & w_pre[l][b+(1<<l)];
        end else begin : g_pass
          assign w_pre[l+1][b] = w_pre[l][b];
        end
      end
    end
    assign w_sfx = w_pre[LVLS];
  end else begin : g_slow
    always_comb begin
      w_sfx            = '0;
      w_sfx[width-1]   = i_d[width-1];
      for (int b = int'(width) - 2; b >= 0; b--) begin
        w_sfx[b] = i_d[b] & w_sfx[b+1];
      end
    end
  end

  assign o_onehot_c = ~i_d & {1'b1, w_sfx[width-1:1]};

endmodule

// File: rtl/onehot_enc.sv
// One-hot first-zero position to leading-one count; no zero found means width.
module onehot_enc
  import lau_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0]                 i_onehot,
  output logic [cnt_width(width)-1:0]      o_cnt_c
);

  localparam int unsigned CW = cnt_width(width);

  logic [CW-1:0] w_enc;

  always_comb begin
    w_enc = '0;
    for (int i = 0; i < int'(width); i++) begin
      if (i_onehot[i]) w_enc = w_enc | CW'(int'(width) - 1 - i);
    end
  end

  assign o_cnt_c = (|i_onehot) ? w_enc : CW'(width);

endmodule

// File: rtl/lead_one_norm.sv
// Leading-one/zero count and left-normalise with valid/ready handshake.
// Define LAU_NORM_PIPE2_EN for a two-stage (detect | shift) pipeline.
module lead_one_norm
  import lau_pkg::*;
#(
  parameter int unsigned     width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [width-1:0]              a_i,
  input  logic                          lzc_mode_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [width-1:0]              data_o,
  output logic [cnt_width(width)-1:0]   cnt_o,
  output logic                          full_o
);

  localparam int unsigned CW = cnt_width(width);

  logic [width-1:0] w_d;
  logic [width-1:0] w_onehot;
  logic [CW-1:0]    w_cnt;
  logic [width-1:0] w_src_a;
  logic [CW-1:0]    w_src_cnt;
  logic             w_src_valid;
  logic [width-1:0] w_sh;
  logic             w_out_rdy;

  lau_norm_res r_res;
  logic        r_valid;

  assign w_d = lzc_mode_i ? ~a_i : a_i;

  LeadOneDet #(
    .width(width),
    .speed(speed)
  ) u_lod (
    .i_d       (w_d),
    .o_onehot_c(w_onehot)
  );

  onehot_enc #(
    .width(width)
  ) u_enc (
    .i_onehot(w_onehot),
    .o_cnt_c (w_cnt)
  );

  assign w_out_rdy = !r_valid || ready_i;

`ifdef LAU_NORM_PIPE2_EN
  logic             r1_valid;
  logic [width-1:0] r1_d;
  logic             r1_mode;
  logic [CW-1:0]    r1_cnt;

  assign ready_o = !r1_valid || w_out_rdy;

  // Detection stage: keep D and its mode so the original operand can be rebuilt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r1_valid <= 1'b0;
      r1_d     <= '0;
      r1_mode  <= 1'b0;
      r1_cnt   <= '0;
    end else begin
      if (ready_o) r1_valid <= valid_i;
      if (valid_i && ready_o) begin
        r1_d    <= w_d;
        r1_mode <= lzc_mode_i;
        r1_cnt  <= w_cnt;
      end
    end
  end

  assign w_src_a     = r1_mode ? ~r1_d : r1_d;
  assign w_src_cnt   = r1_cnt;
  assign w_src_valid = r1_valid;
`else
  assign ready_o     = w_out_rdy;
  assign w_src_a     = a_i;
  assign w_src_cnt   = w_cnt;
  assign w_src_valid = valid_i;
`endif

  // A shift by width already yields zero, which covers the all-ones case.
  assign w_sh = w_src_a << w_src_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_res   <= '0;
    end else begin
      if (w_out_rdy) r_valid <= w_src_valid;
      if (w_src_valid && w_out_rdy) begin
        r_res.data <= LAU_MAX_W'(w_sh);
        r_res.cnt  <= LAU_MAX_CW'(w_src_cnt);
        r_res.full <= (w_src_cnt == CW'(width));
      end
    end
  end

  logic w_unused_res;
  assign w_unused_res = ^r_res;

  assign valid_o = r_valid;
  assign data_o  = r_res.data[width-1:0];
  assign cnt_o   = r_res.cnt[CW-1:0];
  assign full_o  = r_res.full;

endmodule

// File: tb/tb_lead_one_norm.sv
// Self-checking bench for lead_one_norm (width 8) against a counting reference model.
// Expected latency follows LAU_NORM_PIPE2_EN.
module tb_lead_one_norm;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W) + 1;
`ifdef LAU_NORM_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          lzc_mode_i = 1'b0;
  logic [W-1:0]  a_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic [CW-1:0] cnt_o;
  logic          full_o;

  lead_one_norm #(
    .width(W)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .lzc_mode_i(lzc_mode_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .cnt_o     (cnt_o),
    .full_o    (full_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    logic          full;
    int            acc;
  } exp_t;

  exp_t          q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  bit            lat_chk = 1'b0;
  bit            prev_hold = 1'b0;
  logic [W-1:0]  cur_d;
  logic [CW-1:0] cur_c;
  logic          cur_f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Count leading ones of the detected operand by scanning from the MSB.
  function automatic void ref_norm(input logic [W-1:0] a, input logic m,
                                   output logic [W-1:0] d, output logic [CW-1:0] c,
                                   output logic f);
    logic [W-1:0] det;
    int n;
    det = m ? ~a : a;
    n = 0;
    while (n < int'(W) && det[W-1-n]) n++;
    c = CW'(n);
    f = (n == int'(W));
    d = (n == int'(W)) ? '0 : W'(a << n);
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic m, input logic [W-1:0] ed,
                       input logic [CW-1:0] ec, input logic ef);
    valid_i = 1'b1; a_i = a; lzc_mode_i = m;
    cur_d = ed; cur_c = ec; cur_f = ef;
  endtask

  task automatic drive_rand(input bit v);
    logic [W-1:0]  a, ed;
    logic [CW-1:0] ec;
    logic          m, ef;
    a = W'($urandom);
    m = 1'($urandom);
    ref_norm(a, m, ed, ec, ef);
    drive(a, m, ed, ec, ef);
    valid_i = v;
  endtask

  // Observe between edges: check visible output against the queue head, then record transfers.
  task automatic sample();
    if (prev_hold) chk("hold_valid", 32'(valid_o), 32'd1);
    if (valid_o) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(valid_o), 32'd0);
      end else begin
        chk("data", 32'(data_o), 32'(q[0].data));
        chk("cnt", 32'(cnt_o), 32'(q[0].cnt));
        chk("full", 32'(full_o), 32'(q[0].full));
        if (ready_i) begin
          if (lat_chk) chk("latency", 32'(cyc - q[0].acc + 1), 32'(LAT));
          void'(q.pop_front());
        end
      end
    end
    prev_hold = valid_o && !ready_i;
    if (valid_i && ready_o) q.push_back('{cur_d, cur_c, cur_f, cyc + 1});
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid_o"}, 32'(valid_o), 32'd0);
    chk({tag, "_data_o"}, 32'(data_o), 32'd0);
    chk({tag, "_cnt_o"}, 32'(cnt_o), 32'd0);
    chk({tag, "_full_o"}, 32'(full_o), 32'd0);
    chk({tag, "_ready_o"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_ni = 1'b0;
    #1 chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
    ready_i = 1'b1;
    lat_chk = 1'b1;

    // Directed vectors with literal expectations.
    drive(8'b11101010, 1'b0, 8'b01010000, CW'(3), 1'b0); tick();
    drive(8'b00010110, 1'b1, 8'b10110000, CW'(3), 1'b0); tick();
    drive(8'hFF, 1'b0, 8'h00, CW'(8), 1'b1); tick();
    drive(8'h00, 1'b0, 8'h00, CW'(0), 1'b0); tick();
    drive(8'h00, 1'b1, 8'h00, CW'(8), 1'b1); tick();
    drive(8'hFF, 1'b1, 8'hFF, CW'(0), 1'b0); tick();
    drive(8'b10000001, 1'b0, 8'b00000010, CW'(1), 1'b0); tick();
    valid_i = 1'b0;
    repeat (4) tick();
    chk("directed_drain", 32'(q.size()), 32'd0);

    // Backpressure: downstream stalled for 3 cycles with back-to-back inputs.
    lat_chk = 1'b0;
    ready_i = 1'b0;
    repeat (3) begin drive_rand(1'b1); tick(); end
    chk("bp_ready_o", 32'(ready_o), 32'd0);
    chk("bp_occupancy", 32'(q.size()), 32'(LAT));
    ready_i = 1'b1;
    repeat (4) begin drive_rand(1'b1); tick(); end
    valid_i = 1'b0;
    repeat (4) tick();
    chk("bp_drain", 32'(q.size()), 32'd0);

    // Reset with operands in flight: they must never reappear.
    ready_i = 1'b0;
    repeat (2) begin drive_rand(1'b1); tick(); end
    valid_i = 1'b0;
    rst_ni = 1'b0;
    #1 chk_reset_outputs("midreset");
    q.delete();
    prev_hold = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    ready_i = 1'b1;
    lat_chk = 1'b1;

    // Random stream, downstream always ready: latency is exact.
    repeat (200) begin drive_rand($urandom_range(0, 3) != 0); tick(); end

    // Random stream with random backpressure.
    lat_chk = 1'b0;
    repeat (300) begin
      ready_i = ($urandom_range(0, 2) != 0);
      drive_rand($urandom_range(0, 3) != 0);
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (10) tick();
    chk("final_drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
